// File: rtl/cla_add_scheduler_if.sv
// -----------------------------------------------------------------------------
// cla_add_scheduler_if
// Bundles the two request channels, the response channel and the busy flag of
// cla_add_scheduler.
//   req0_* / req1_* : valid/ready request with W-bit operands a, b and cin
//   rsp_*           : valid/ready response with owner id, W-bit sum, carry-out
//   busy            : scheduler is not idle
// The master modport is the requester/consumer side; the slave modport is the
// scheduler side.
// -----------------------------------------------------------------------------
interface cla_add_scheduler_if #(
    parameter int WORDS = 2
);
    localparam int W = 32 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;

    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/cla_add_scheduler.sv
// -----------------------------------------------------------------------------
// carry_look_ahead_adder
// 32-bit adder built from 4-bit lookahead groups; group carries are formed from
// group generate/propagate terms.
//   A, B : addends      cin  : carry in
//   S    : sum          cout : carry out
// -----------------------------------------------------------------------------
module carry_look_ahead_adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] S,
    output logic        cout
);
    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [32:0] c_s;

    // Bit and group lookahead carries
    always_comb begin
        g_s = A & B;
        p_s = A ^ B;
        c_s = 33'd0;
        c_s[0] = cin;
        for (int grp = 0; grp < 8; grp++) begin
            c_s[4*grp+1] = g_s[4*grp] | (p_s[4*grp] & c_s[4*grp]);
            c_s[4*grp+2] = g_s[4*grp+1] | (p_s[4*grp+1] & g_s[4*grp])
                         | (p_s[4*grp+1] & p_s[4*grp] & c_s[4*grp]);
            c_s[4*grp+3] = g_s[4*grp+2] | (p_s[4*grp+2] & g_s[4*grp+1])
                         | (p_s[4*grp+2] & p_s[4*grp+1] & g_s[4*grp])
                         | (p_s[4*grp+2] & p_s[4*grp+1] & p_s[4*grp] & c_s[4*grp]);
            // Group generate / propagate drive the next group's carry-in
            c_s[4*grp+4] = (g_s[4*grp+3] | (p_s[4*grp+3] & g_s[4*grp+2])
                         | (p_s[4*grp+3] & p_s[4*grp+2] & g_s[4*grp+1])
                         | (p_s[4*grp+3] & p_s[4*grp+2] & p_s[4*grp+1] & g_s[4*grp]))
                         | ((&p_s[4*grp +: 4]) & c_s[4*grp]);
        end
        S    = p_s ^ c_s[31:0];
        cout = c_s[32];
    end
endmodule

// -----------------------------------------------------------------------------
// cla_add_scheduler
// Shares one 32-bit carry_look_ahead_adder between two requesters, adding
// WORDS x 32-bit operands one word per cycle with the carry chained through a
// register. Round-robin arbitration in IDLE; result held in DONE until taken.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/response channels and busy flag (slave side)
// -----------------------------------------------------------------------------
module cla_add_scheduler #(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_add_scheduler_if.slave    bus
);
    localparam int W  = 32 * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [KW-1:0] k_q, k_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          cin_q, cin_d;
    logic          id_q, id_d;
    logic [W-1:0]  rsp_sum_q, rsp_sum_d;
    logic          rsp_cout_q, rsp_cout_d;
    logic          rsp_id_q, rsp_id_d;

    logic          grant0_s, grant1_s;
    logic          ready0_s, ready1_s;
    logic [31:0]   add_a_s, add_b_s, add_s_s;
    logic          add_cin_s, add_cout_s;
    int            idx_s;

    carry_look_ahead_adder u_cla (
        .A    (add_a_s),
        .B    (add_b_s),
        .cin  (add_cin_s),
        .S    (add_s_s),
        .cout (add_cout_s)
    );

    // Arbitration and word-slice selection for the shared adder
    always_comb begin
        // Pointer only breaks ties; a lone requester is always granted
        grant0_s  = bus.req0_valid && (!bus.req1_valid || (ptr_q == 1'b0));
        grant1_s  = bus.req1_valid && (!bus.req0_valid || (ptr_q == 1'b1));
        ready0_s  = (state_q == IDLE) && rst_n && grant0_s;
        ready1_s  = (state_q == IDLE) && rst_n && grant1_s;
        idx_s     = int'(k_q);
        add_a_s   = a_q[idx_s*32 +: 32];
        add_b_s   = b_q[idx_s*32 +: 32];
        add_cin_s = (k_q == '0) ? cin_q : carry_q;
    end

    // Next-state logic for the IDLE/ADD/DONE sequencer
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        k_d        = k_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        id_d       = id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (ready0_s) begin
                    a_d     = bus.req0_a;
                    b_d     = bus.req0_b;
                    cin_d   = bus.req0_cin;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    k_d     = '0;
                    state_d = ADD;
                end else if (ready1_s) begin
                    a_d     = bus.req1_a;
                    b_d     = bus.req1_b;
                    cin_d   = bus.req1_cin;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    k_d     = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                rsp_sum_d[idx_s*32 +: 32] = add_s_s;
                carry_d = add_cout_s;
                if (k_q == K_LAST) begin
                    rsp_cout_d = add_cout_s;
                    rsp_id_d   = id_q;
                    k_d        = '0;
                    state_d    = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            k_q        <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            k_q        <= k_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            id_q       <= id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_cout   = rsp_cout_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/cla_add_scheduler.md
Name: cla_add_scheduler

Overview:
Sequencer and arbiter that shares one 32-bit carry_look_ahead_adder instance (ports A, B, cin, S, cout) between two requesters. It performs wide unsigned additions of WORDS x 32 bits, one 32-bit word per cycle, chaining the carry through a register. A round-robin arbiter grants the adder, and a valid/ready response channel returns the result. The block instantiates the existing carry_look_ahead_adder internally and is the lab's first multi-cycle arithmetic controller.

Parameters:
WORDS, 2, number of 32-bit words per operand (>=1); operand and result width W = 32*WORDS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_a  input  W  requester 0 operand A
req0_b  input  W  requester 0 operand B
req0_cin  input  1  requester 0 carry-in
req1_valid  input  1  requester 1 has an operation pending
req1_ready  output  1  requester 1 accept
req1_a  input  W  requester 1 operand A
req1_b  input  W  requester 1 operand B
req1_cin  input  1  requester 1 carry-in
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result when valid&ready
rsp_id  output  1  requester index owning the result
rsp_sum  output  W  (A+B+cin) mod 2^W
rsp_cout  output  1  carry out of the top word
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: on a rising edge with rst_n=0, state=IDLE, round-robin pointer=0 (req0 preferred), word index=0, carry reg=0, and rsp_valid/rsp_id/rsp_sum/rsp_cout/busy all 0. reqN_ready is forced 0 while rst_n=0.
- FSM states are IDLE, ADD and DONE.
- IDLE grant rules:
  - One valid requester: grant it.
  - Both valid: grant the requester the pointer selects.
  - reqN_ready = IDLE && rst_n && grantN. At most one ready is high per cycle.
- IDLE accept: on the edge where the granted valid&ready holds, capture a, b, cin and id. Set the pointer to the non-granted index, word index to 0, and go to ADD.
- ADD (one cycle per word k = 0..WORDS-1):
  - Adder inputs: A = a[32k+31:32k], B = b[32k+31:32k], cin = (k==0) ? captured cin : carry reg.
  - At the edge: rsp_sum[32k+31:32k] <= S, carry reg <= cout, k <= k+1.
  - When k == WORDS-1, also rsp_cout <= cout, rsp_id <= captured id, and state <= DONE.
- DONE: rsp_valid=1. rsp_id/rsp_sum/rsp_cout stay stable until the edge with rsp_valid&rsp_ready, then IDLE. No accept is possible outside IDLE.
- Latency and throughput: with acceptance at edge T, rsp_valid rises after edge T+WORDS. Minimum initiation interval is WORDS+2 cycles with rsp_ready held high.
- Width and arithmetic: unsigned and modular. Overflow appears only in rsp_cout. WORDS=1 gives a single ADD cycle.
- Idle outputs: rsp_sum/rsp_cout/rsp_id hold their last values in IDLE and are valid only with rsp_valid. A partially written rsp_sum during ADD is not observable as valid.
- Fairness: the pointer changes only on accept. A requester that holds valid is served within one other transaction.
- Reset mid-operation (ADD or DONE): the in-flight operation is discarded and no response is produced. rsp_valid is 0 after the reset edge, and the block operates normally from the first edge with rst_n=1.
- Request inputs may change freely when not accepted. Captured operands are immune to input changes after the accept edge.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req0_valid=1 -> req0_ready=0, rsp_valid=0, busy=0, rsp_sum=0. After release, req0 is accepted on the first edge.
2. Carry chaining (WORDS=2): req0 a=0x00000000_FFFFFFFF, b=0x1, cin=0 -> rsp_sum=0x00000001_00000000, rsp_cout=0, rsp_id=0. rsp_valid rises 2 cycles after the accept edge.
3. Wrap-around: req1 a=0xFFFFFFFF_FFFFFFFF, b=0, cin=1 -> rsp_sum=0, rsp_cout=1, rsp_id=1. A second case, a=0x12345678_9ABCDEF0, b=0x11111111_11111111, cin=0 -> sum=0x23456789_ABCDF001, cout=0.
4. Round-robin, with both requesters valid continuously after reset and rsp_ready=1:
   - Grants go 0,1,0,1, and ready never overlaps.
   - Successive accepts are 4 cycles apart.
   - Each rsp_id matches its operands (req0 3+4 -> 7, req1 10+20+cin1 -> 31).
5. Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_sum/rsp_id stay stable, busy=1, both readys 0. rsp_ready=1 gives a handshake, and IDLE follows on the next cycle.
6. Reset mid-ADD: assert rst_n=0 for 1 cycle during word 0 -> no rsp_valid ever appears for that operation and the pointer returns to 0. A following req0 5+6 returns 11 correctly.
